// File: rtl/scu_dsp_dma_ctrl.sv
// ---------------------------------------------------------------------------
// scu_dsp_dma_ctrl
//   Sequences the SCU DSP D0-bus DMA channel onto the SCU external bus.
//   Owns the RA0 (read) and WA0 (write) word-address registers and services
//   one DSP word request at a time with a single external bus cycle.
//
// Optional feature macro: SCU_DSP_DMA_TIMEOUT_EN
//   When defined, a WAIT-state watchdog aborts a bus cycle that is not
//   acknowledged within TIMEOUT_CYC clocks, raises the sticky ERR flag and
//   finishes the transfer with DMA_END (no DMA_ACK).
//
// Ports
//   CLK, RST_N          clock, asynchronous active-low reset
//   CE_R, CE_F          DSP phase enables (DMA_ACK / DMA_END handshake)
//   DSO, RA0W, WA0W     address register load path
//   ADD_SEL             per-word address step select (0,1,2,4..64 words)
//   DMA_REQ/WE/RUN/LAST DSP word request and its attributes
//   DMA_DO, DMA_DI      DSP write data / read data
//   DMA_ACK, DMA_END    word done / transfer done
//   BUS_REQ/A/WE/DO     external bus cycle request, address, dir, wdata
//   BUS_DI, BUS_ACK     external read data and cycle-done strobe
//   BUSY, ERR           not idle / sticky timeout error
// ---------------------------------------------------------------------------
module scu_dsp_dma_ctrl #(
  parameter int AW          = 27,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic          CLK,
  input  logic          RST_N,
  input  logic          CE_R,
  input  logic          CE_F,
  input  logic [31:0]   DSO,
  input  logic          RA0W,
  input  logic          WA0W,
  input  logic [2:0]    ADD_SEL,
  input  logic          DMA_REQ,
  input  logic          DMA_WE,
  input  logic          DMA_RUN,
  input  logic          DMA_LAST,
  input  logic [31:0]   DMA_DO,
  output logic [31:0]   DMA_DI,
  output logic          DMA_ACK,
  output logic          DMA_END,
  output logic          BUS_REQ,
  output logic [AW-1:0] BUS_A,
  output logic          BUS_WE,
  output logic [31:0]   BUS_DO,
  input  logic [31:0]   BUS_DI,
  input  logic          BUS_ACK,
  output logic          BUSY,
  output logic          ERR
);

  localparam int WW = AW - 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_ACK,
    S_END
  } state_t;

  state_t state, state_nxt;

  logic [WW-1:0] ra0, wa0;
  logic [WW-1:0] step_sel, step_r;
  logic          we_r, last_r;
  logic          start, bus_done, tmo;

  // Word-step decode: 0 stays put, n>0 steps 2^(n-1) words.
  always_comb begin
    step_sel = '0;
    case (ADD_SEL)
      3'd0:    step_sel = '0;
      default: step_sel = WW'(1) << (ADD_SEL - 3'd1);
    endcase
  end

  assign start    = (state == S_IDLE) && DMA_REQ && DMA_RUN && !DMA_ACK;
  assign bus_done = (state == S_WAIT) && BUS_ACK;

`ifdef SCU_DSP_DMA_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  logic [CW-1:0] tmo_cnt;
  logic          err_r;

  // Counter is cleared on the REQ->WAIT step, so WAIT lasts TIMEOUT_CYC clocks.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      tmo_cnt <= '0;
      err_r   <= 1'b0;
    end else begin
      if (state == S_REQ)       tmo_cnt <= '0;
      else if (state == S_WAIT) tmo_cnt <= tmo_cnt + 1'b1;
      if (tmo)                  err_r   <= 1'b1;
    end
  end

  assign tmo = (state == S_WAIT) && !BUS_ACK && (tmo_cnt == CW'(TIMEOUT_CYC - 1));
  assign ERR = err_r;

  logic unused;
  assign unused = ^DSO[31:WW];
`else
  assign tmo = 1'b0;
  assign ERR = 1'b0;

  logic unused;
  assign unused = ^{DSO[31:WW], TIMEOUT_CYC};
`endif

  // State register
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (start) state_nxt = S_REQ;
      S_REQ:  state_nxt = S_WAIT;
      S_WAIT: begin
        if (BUS_ACK)  state_nxt = S_ACK;
        else if (tmo) state_nxt = S_END;
      end
      S_ACK:  if (CE_R) state_nxt = last_r ? S_END : S_IDLE;
      S_END:  if (CE_F) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    BUSY    = (state != S_IDLE);
    BUS_REQ = (state == S_REQ) || (state == S_WAIT);
    DMA_ACK = (state == S_ACK);
    DMA_END = (state == S_END);
  end

  // Datapath: the cycle's address is captured at IDLE exit, so a later
  // RA0W/WA0W load only affects the next cycle. A load beats the increment.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      ra0    <= '0;
      wa0    <= '0;
      step_r <= '0;
      we_r   <= 1'b0;
      last_r <= 1'b0;
      BUS_A  <= '0;
      BUS_DO <= '0;
      DMA_DI <= '0;
    end else begin
      if (start) begin
        we_r   <= DMA_WE;
        last_r <= DMA_LAST;
        step_r <= step_sel;
        BUS_DO <= DMA_DO;
        BUS_A  <= {(DMA_WE ? wa0 : ra0), 2'b00};
      end

      if (bus_done && !we_r) DMA_DI <= BUS_DI;

      if (RA0W)                   ra0 <= DSO[WW-1:0];
      else if (bus_done && !we_r) ra0 <= ra0 + step_r;

      if (WA0W)                   wa0 <= DSO[WW-1:0];
      else if (bus_done && we_r)  wa0 <= wa0 + step_r;
    end
  end

  assign BUS_WE = we_r;

endmodule

// File: tb/tb_scu_dsp_dma_ctrl.sv
module tb_scu_dsp_dma_ctrl;

  localparam int AW = 27;
`ifdef SCU_DSP_DMA_TIMEOUT_EN
  localparam int TB_TMO = 8;
`else
  localparam int TB_TMO = 255;
`endif

  logic          CLK = 1'b0;
  logic          RST_N;
  logic          CE_R, CE_F;
  logic [31:0]   DSO;
  logic          RA0W, WA0W;
  logic [2:0]    ADD_SEL;
  logic          DMA_REQ, DMA_WE, DMA_RUN, DMA_LAST;
  logic [31:0]   DMA_DO, DMA_DI;
  logic          DMA_ACK, DMA_END;
  logic          BUS_REQ, BUS_WE;
  logic [AW-1:0] BUS_A;
  logic [31:0]   BUS_DO, BUS_DI;
  logic          BUS_ACK, BUSY, ERR;

  int n_checks = 0;
  int n_fails  = 0;

  always #5 CLK = ~CLK;

  scu_dsp_dma_ctrl #(.AW(AW), .TIMEOUT_CYC(TB_TMO)) dut (
    .CLK(CLK), .RST_N(RST_N), .CE_R(CE_R), .CE_F(CE_F), .DSO(DSO),
    .RA0W(RA0W), .WA0W(WA0W), .ADD_SEL(ADD_SEL), .DMA_REQ(DMA_REQ),
    .DMA_WE(DMA_WE), .DMA_RUN(DMA_RUN), .DMA_LAST(DMA_LAST),
    .DMA_DO(DMA_DO), .DMA_DI(DMA_DI), .DMA_ACK(DMA_ACK), .DMA_END(DMA_END),
    .BUS_REQ(BUS_REQ), .BUS_A(BUS_A), .BUS_WE(BUS_WE), .BUS_DO(BUS_DO),
    .BUS_DI(BUS_DI), .BUS_ACK(BUS_ACK), .BUSY(BUSY), .ERR(ERR)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic load_ra(input logic [31:0] v);
    @(negedge CLK); RA0W = 1'b1; DSO = v;
    @(negedge CLK); RA0W = 1'b0;
  endtask

  task automatic load_wa(input logic [31:0] v);
    @(negedge CLK); WA0W = 1'b1; DSO = v;
    @(negedge CLK); WA0W = 1'b0;
  endtask

  // One word with BUS_ACK in the first WAIT cycle and CE_R/CE_F held high.
  task automatic word(input logic we, input logic last, input logic [31:0] dout,
                      input logic [31:0] din, input logic [31:0] exp_a);
    @(negedge CLK); DMA_REQ = 1'b1; DMA_WE = we; DMA_LAST = last; DMA_DO = dout;
    @(negedge CLK); DMA_REQ = 1'b0;
    chk("bus_req", {31'b0, BUS_REQ}, 32'd1);
    chk("bus_a", {5'b0, BUS_A}, exp_a);
    chk("bus_we", {31'b0, BUS_WE}, {31'b0, we});
    if (we) chk("bus_do", BUS_DO, dout);
    @(negedge CLK); BUS_DI = din; BUS_ACK = 1'b1;
    @(negedge CLK); BUS_ACK = 1'b0;
    chk("dma_ack", {31'b0, DMA_ACK}, 32'd1);
    chk("bus_req_low", {31'b0, BUS_REQ}, 32'd0);
    if (!we) chk("dma_di", DMA_DI, din);
    @(negedge CLK);
    chk("dma_end", {31'b0, DMA_END}, {31'b0, last});
    chk("ack_low", {31'b0, DMA_ACK}, 32'd0);
    if (last) @(negedge CLK);
    chk("idle", {31'b0, BUSY}, 32'd0);
  endtask

  initial begin
    int unsigned cnt;
    logic        seen_ack;

    RST_N = 1'b0; CE_R = 1'b1; CE_F = 1'b1; DSO = '0; RA0W = 1'b0; WA0W = 1'b0;
    ADD_SEL = 3'd1; DMA_REQ = 1'b0; DMA_WE = 1'b0; DMA_RUN = 1'b1;
    DMA_LAST = 1'b0; DMA_DO = '0; BUS_DI = '0; BUS_ACK = 1'b0;

    // Reset state
    repeat (2) @(negedge CLK);
    chk("rst_busy", {31'b0, BUSY}, 32'd0);
    chk("rst_req", {31'b0, BUS_REQ}, 32'd0);
    chk("rst_a", {5'b0, BUS_A}, 32'd0);
    chk("rst_di", DMA_DI, 32'd0);
    chk("rst_ack_end", {30'b0, DMA_ACK, DMA_END}, 32'd0);
    chk("rst_err", {31'b0, ERR}, 32'd0);
    RST_N = 1'b1;

    // 1: 3-word read from word 0x100, step 1
    load_ra(32'h100);
    word(1'b0, 1'b0, 32'h0, 32'hA, 32'h400);
    word(1'b0, 1'b0, 32'h0, 32'hB, 32'h404);
    word(1'b0, 1'b1, 32'h0, 32'hC, 32'h408);

    // 2: 2-word write from word 0x20, step 4
    ADD_SEL = 3'd3;
    load_wa(32'h20);
    word(1'b1, 1'b0, 32'h11111111, 32'h0, 32'h80);
    word(1'b1, 1'b1, 32'h22222222, 32'h0, 32'h90);
    word(1'b1, 1'b0, 32'h33333333, 32'h0, 32'hA0);  // WA0 reached 0x28
    ADD_SEL = 3'd1;
    word(1'b0, 1'b0, 32'h0, 32'hD, 32'h40C);        // RA0 reached 0x103
    chk("di_hold_write", DMA_DI, 32'hD);

    // 3: wrap at the top word
    load_ra(32'h01FF_FFFF);
    word(1'b0, 1'b0, 32'h0, 32'h1234, 32'h7FF_FFFC);

    // 4: delayed BUS_ACK, gated CE_R, ignored second request (RA0 wrapped to 0)
    @(negedge CLK); DMA_REQ = 1'b1; DMA_WE = 1'b0; DMA_LAST = 1'b0;
    @(negedge CLK); DMA_REQ = 1'b0; CE_R = 1'b0;
    chk("t4_bus_a", {5'b0, BUS_A}, 32'h0);
    cnt = BUS_REQ ? 1 : 0;
    for (int unsigned i = 1; i <= 10; i++) begin
      @(negedge CLK);
      if (BUS_REQ) cnt++;
      if (i == 10) begin BUS_DI = 32'h5A5A; BUS_ACK = 1'b1; end
    end
    @(negedge CLK); BUS_ACK = 1'b0; DMA_REQ = 1'b1;
    chk("t4_req_cycles", cnt, 32'd11);
    chk("t4_req_low", {31'b0, BUS_REQ}, 32'd0);
    chk("t4_di", DMA_DI, 32'h5A5A);
    cnt = 0;
    for (int unsigned i = 0; i < 5; i++) begin
      if (DMA_ACK) cnt++;
      @(negedge CLK);
    end
    chk("t4_ack_held", cnt, 32'd5);
    chk("t4_ack_still", {31'b0, DMA_ACK}, 32'd1);
    chk("t4_no_service", {31'b0, BUS_REQ}, 32'd0);
    CE_R = 1'b1; DMA_REQ = 1'b0;
    @(negedge CLK);
    chk("t4_ack_drop", {31'b0, DMA_ACK}, 32'd0);
    chk("t4_idle", {31'b0, BUSY}, 32'd0);

    // 5: reset in WAIT
    load_ra(32'h50);
    @(negedge CLK); DMA_REQ = 1'b1; DMA_WE = 1'b0;
    @(negedge CLK); DMA_REQ = 1'b0;
    @(negedge CLK);
    chk("t5_in_wait", {31'b0, BUS_REQ}, 32'd1);
    RST_N = 1'b0;
    #1;
    chk("t5_rst_req", {31'b0, BUS_REQ}, 32'd0);
    chk("t5_rst_busy", {31'b0, BUSY}, 32'd0);
    chk("t5_rst_a", {5'b0, BUS_A}, 32'd0);
    chk("t5_rst_di", DMA_DI, 32'd0);
    @(negedge CLK); RST_N = 1'b1;
    word(1'b0, 1'b0, 32'h0, 32'h77, 32'h0);

    // Step 0 hits the same word
    ADD_SEL = 3'd0;
    word(1'b0, 1'b0, 32'h0, 32'h88, 32'h4);
    word(1'b0, 1'b0, 32'h0, 32'h99, 32'h4);
    ADD_SEL = 3'd1;

`ifdef SCU_DSP_DMA_TIMEOUT_EN
    // 6: BUS_ACK never arrives
    load_ra(32'h10);
    @(negedge CLK); DMA_REQ = 1'b1; DMA_WE = 1'b0; DMA_LAST = 1'b0;
    @(negedge CLK); DMA_REQ = 1'b0;
    cnt = BUS_REQ ? 1 : 0;
    seen_ack = 1'b0;
    for (int unsigned i = 0; i < 30; i++) begin
      @(negedge CLK);
      if (DMA_ACK) seen_ack = 1'b1;
      if (!BUS_REQ) break;
      cnt++;
    end
    chk("t6_req_cycles", cnt, 32'd9);
    chk("t6_err", {31'b0, ERR}, 32'd1);
    chk("t6_end", {31'b0, DMA_END}, 32'd1);
    chk("t6_no_ack", {31'b0, seen_ack}, 32'd0);
    @(negedge CLK);
    chk("t6_idle", {31'b0, BUSY}, 32'd0);
    word(1'b0, 1'b0, 32'h0, 32'h1, 32'h40);           // no advance after abort
    chk("t6_err_sticky", {31'b0, ERR}, 32'd1);
`else
    seen_ack = 1'b0;
    chk("err_tied", {31'b0, ERR, seen_ack}, 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
